// File: rtl/cpu_seq_ctrl.sv
// Sequencer and execution core for the 8-bit test CPU.
// Four registers, {Z,N,C,V} flags, request/ready memory port.
module cpu_seq_ctrl #(
    parameter bit ILLEGAL_HALTS = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid_i,
    input  logic [15:0] instr_i,
    output logic        instr_ready_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [7:0]  mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    input  logic [7:0]  mem_rdata_i,
    input  logic        mem_ready_i,
    output logic        done_o,
    output logic [3:0]  flags_o
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_e;

    state_e      state_q;
    logic [15:0] ir_q;
    logic [7:0]  rf_q [4];
    logic [3:0]  flags_q;
    logic        done_q;
    logic        rdy_q;
    logic        req_q;
    logic        we_q;
    logic [7:0]  addr_q;
    logic [7:0]  wdata_q;

    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] sum9;
    logic [8:0] dif9;

    assign op   = ir_q[15:12];
    assign rd   = ir_q[11:10];
    assign rs   = ir_q[9:8];
    assign imm  = ir_q[7:0];
    assign a    = rf_q[rd];
    assign b    = rf_q[rs];
    assign sum9 = {1'b0, a} + {1'b0, b};
    assign dif9 = {1'b0, a} - {1'b0, b};

    logic [7:0] res;
    logic [3:0] flags_d;
    logic       wr_en;
    logic       set_zn;
    logic       is_mem;
    logic       is_halt;

    always_comb begin
        res     = 8'h00;
        flags_d = flags_q;
        wr_en   = 1'b0;
        set_zn  = 1'b0;
        is_mem  = 1'b0;
        is_halt = 1'b0;
        unique case (op)
            4'h1: begin
                res = imm; wr_en = 1'b1; set_zn = 1'b1;
            end
            4'h2, 4'h3: is_mem = 1'b1;
            4'h4: begin
                res = sum9[7:0]; wr_en = 1'b1; set_zn = 1'b1;
                flags_d[1] = sum9[8];
                flags_d[0] = (a[7] == b[7]) && (sum9[7] != a[7]);
            end
            4'h5, 4'h9: begin
                res = dif9[7:0]; wr_en = (op == 4'h5); set_zn = 1'b1;
                flags_d[1] = dif9[8];
                flags_d[0] = (a[7] != b[7]) && (dif9[7] != a[7]);
            end
            4'h6, 4'h7, 4'h8: begin
                res = (op == 4'h6) ? (a & b) :
                      (op == 4'h7) ? (a | b) : (a ^ b);
                wr_en = 1'b1; set_zn = 1'b1;
                flags_d[1:0] = 2'b00;
            end
            4'hF: is_halt = 1'b1;
            4'hA, 4'hB, 4'hC, 4'hD, 4'hE: is_halt = ILLEGAL_HALTS;
            default: ;
        endcase
        if (set_zn) flags_d[3:2] = {res == 8'h00, res[7]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            for (int i = 0; i < 4; i++) rf_q[i] <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b1;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            unique case (state_q)
                S_FETCH: if (instr_valid_i) begin
                    ir_q    <= instr_i;
                    rdy_q   <= 1'b0;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_halt) begin
                        done_q  <= 1'b1;
                        state_q <= S_HALT;
                    end else if (is_mem) begin
                        req_q   <= 1'b1;
                        we_q    <= (op == 4'h3);
                        addr_q  <= imm;
                        wdata_q <= a;
                        state_q <= S_MEM;
                    end else begin
                        if (wr_en) rf_q[rd] <= res;
                        flags_q <= flags_d;
                        rdy_q   <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_MEM: if (mem_ready_i) begin
                    if (!we_q) begin
                        rf_q[rd]     <= mem_rdata_i;
                        flags_q[3:2] <= {mem_rdata_i == 8'h00, mem_rdata_i[7]};
                    end
                    req_q   <= 1'b0;
                    rdy_q   <= 1'b1;
                    state_q <= S_FETCH;
                end
                S_HALT: ;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign instr_ready_o = rdy_q;
    assign mem_req_o     = req_q;
    assign mem_we_o      = we_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign done_o        = done_q;
    assign flags_o       = flags_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: flag and memory-request
// expectations are queued by stimulus and checked by monitors.
module tb_cpu_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_ready;
    logic        mem_req, mem_we;
    logic [7:0]  mem_addr, mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready = 1'b0;
    logic        done;
    logic [3:0]  flags;

    logic        b_valid = 1'b0;
    logic [15:0] b_instr = '0;
    logic        b_ready, b_req, b_we, b_done;
    logic [7:0]  b_addr, b_wdata;
    logic [3:0]  b_flags;

    cpu_seq_ctrl #(.ILLEGAL_HALTS(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .instr_valid_i(instr_valid), .instr_i(instr),
        .instr_ready_o(instr_ready),
        .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
        .done_o(done), .flags_o(flags)
    );

    cpu_seq_ctrl #(.ILLEGAL_HALTS(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .instr_valid_i(b_valid), .instr_i(b_instr),
        .instr_ready_o(b_ready),
        .mem_req_o(b_req), .mem_we_o(b_we),
        .mem_addr_o(b_addr), .mem_wdata_o(b_wdata),
        .mem_rdata_i(8'h00), .mem_ready_i(1'b0),
        .done_o(b_done), .flags_o(b_flags)
    );

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } mexp_t;

    int checks = 0;
    int errors = 0;
    logic [3:0] fq[$];
    mexp_t      mq[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op,
        input logic [1:0] rd, input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    // Memory responder: holds mem_ready low for wait_set cycles
    int         wait_set = 0;
    int         inmem = 0;
    logic [7:0] rdata_v = 8'h00;
    assign mem_rdata = rdata_v;

    always @(negedge clk) begin
        if (mem_req) begin
            mem_ready = (inmem >= wait_set);
            inmem++;
        end else begin
            mem_ready = 1'b0;
            inmem = 0;
        end
    end

    // Monitor
    logic  prev_rdy = 1'b1;
    logic  prev_req = 1'b0;
    mexp_t cap;
    mexp_t me;
    logic [3:0] fe;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rdy = 1'b1;
            prev_req = 1'b0;
        end else begin
            if (instr_ready && !prev_rdy) begin
                if (fq.size() == 0) chk("flags_unexpected", 1, 0);
                else begin
                    fe = fq.pop_front();
                    chk("flags", {28'd0, flags}, {28'd0, fe});
                end
            end
            if (mem_req && !prev_req) begin
                if (mq.size() == 0) chk("mem_unexpected", 1, 0);
                else begin
                    me = mq.pop_front();
                    chk("mem_we", {31'd0, mem_we}, {31'd0, me.we});
                    chk("mem_addr", {24'd0, mem_addr}, {24'd0, me.addr});
                    if (me.we)
                        chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, me.wdata});
                end
                cap = {mem_we, mem_addr, mem_wdata};
            end else if (mem_req) begin
                chk("mem_stable", {15'd0, mem_we, mem_addr, mem_wdata},
                    {15'd0, cap});
            end
            prev_rdy = instr_ready;
            prev_req = mem_req;
        end
    end

    // Called at a negedge; returns at a negedge unless exp_lat is 0
    task automatic issue(input logic [15:0] w, input logic [3:0] ef,
                         input bit push_f, input int exp_lat);
        int n;
        if (push_f) fq.push_back(ef);
        instr = w;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 0, 1);
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;
        if (exp_lat > 0) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!instr_ready && n < 50);
            chk("latency", n, exp_lat);
        end
    endtask

    task automatic st(input logic [1:0] r, input logic [7:0] ad,
                      input logic [7:0] v, input logic [3:0] ef);
        mq.push_back({1'b1, ad, v});
        issue(ins(4'h3, r, 2'd0, ad), ef, 1, 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, instr_ready}, 1);
        chk("rst_flags", {28'd0, flags}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_req", {31'd0, mem_req}, 0);
        chk("rst_b_done", {31'd0, b_done}, 0);

        // ADD overflow then carry-out
        issue(ins(4'h1, 2'd0, 2'd0, 8'h7F), 4'b0000, 1, 2);
        issue(ins(4'h1, 2'd1, 2'd0, 8'h01), 4'b0000, 1, 2);
        issue(ins(4'h4, 2'd0, 2'd1, 8'h00), 4'b0101, 1, 2);
        issue(ins(4'h1, 2'd2, 2'd0, 8'hFF), 4'b0101, 1, 2);
        issue(ins(4'h4, 2'd2, 2'd1, 8'h00), 4'b1010, 1, 2);
        st(2'd0, 8'h11, 8'h80, 4'b1010);

        // SUB / CMP borrow
        issue(ins(4'h1, 2'd0, 2'd0, 8'h05), 4'b0010, 1, 2);
        issue(ins(4'h1, 2'd1, 2'd0, 8'h07), 4'b0010, 1, 2);
        issue(ins(4'h9, 2'd0, 2'd1, 8'h00), 4'b0110, 1, 2);
        st(2'd0, 8'h12, 8'h05, 4'b0110);
        issue(ins(4'h5, 2'd1, 2'd1, 8'h00), 4'b1000, 1, 2);
        st(2'd1, 8'h13, 8'h00, 4'b1000);

        // Set C and V, then XOR clears them
        issue(ins(4'h1, 2'd2, 2'd0, 8'h80), 4'b0100, 1, 2);
        issue(ins(4'h1, 2'd3, 2'd0, 8'h80), 4'b0100, 1, 2);
        issue(ins(4'h4, 2'd2, 2'd3, 8'h00), 4'b1011, 1, 2);
        issue(ins(4'h8, 2'd2, 2'd0, 8'h00), 4'b0000, 1, 2);

        // Store with three wait cycles
        issue(ins(4'h1, 2'd3, 2'd0, 8'hA5), 4'b0100, 1, 2);
        wait_set = 3;
        mq.push_back({1'b1, 8'h40, 8'hA5});
        issue(ins(4'h3, 2'd3, 2'd0, 8'h40), 4'b0100, 1, 6);
        wait_set = 0;

        // Zero-wait loads
        rdata_v = 8'h00;
        mq.push_back({1'b0, 8'h10, 8'h00});
        issue(ins(4'h2, 2'd2, 2'd0, 8'h10), 4'b1000, 1, 3);
        st(2'd2, 8'h14, 8'h00, 4'b1000);
        rdata_v = 8'h9C;
        mq.push_back({1'b0, 8'h20, 8'h00});
        issue(ins(4'h2, 2'd1, 2'd0, 8'h20), 4'b0100, 1, 3);
        rdata_v = 8'h00;
        st(2'd1, 8'h21, 8'h9C, 4'b0100);

        // Undefined opcode acts as NOP
        issue(ins(4'hA, 2'd1, 2'd0, 8'hFF), 4'b0100, 1, 2);
        st(2'd1, 8'h22, 8'h9C, 4'b0100);

        // Reset in the middle of a memory access
        issue(ins(4'h1, 2'd0, 2'd0, 8'h33), 4'b0000, 1, 2);
        wait_set = 100;
        mq.push_back({1'b1, 8'h50, 8'h33});
        issue(ins(4'h3, 2'd0, 2'd0, 8'h50), 4'b0000, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("req_before_rst", {31'd0, mem_req}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_req", {31'd0, mem_req}, 0);
        chk("rst_mid_we", {31'd0, mem_we}, 0);
        chk("rst_mid_addr", {24'd0, mem_addr}, 0);
        chk("rst_mid_wdata", {24'd0, mem_wdata}, 0);
        chk("rst_mid_flags", {28'd0, flags}, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_set = 0;
        @(negedge clk);
        chk("rst_mid_ready", {31'd0, instr_ready}, 1);
        st(2'd0, 8'h60, 8'h00, 4'b0000);
        st(2'd3, 8'h63, 8'h00, 4'b0000);

        // HALT is sticky and ignores offered instructions
        issue(ins(4'hF, 2'd0, 2'd0, 8'h00), 4'b0000, 0, 0);
        instr = ins(4'h1, 2'd0, 2'd0, 8'h01);
        instr_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("halt_done", {31'd0, done}, 1);
            chk("halt_ready", {31'd0, instr_ready}, 0);
        end
        chk("halt_flags", {28'd0, flags}, 0);
        instr_valid = 1'b0;

        // Undefined opcode halts when configured to
        b_instr = ins(4'hB, 2'd0, 2'd0, 8'h00);
        b_valid = 1'b1;
        @(posedge clk);
        #1 b_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b_done", {31'd0, b_done}, 1);
        chk("b_ready", {31'd0, b_ready}, 0);

        repeat (3) @(negedge clk);
        chk("fq_empty", fq.size(), 0);
        chk("mq_empty", mq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
